// File: rtl/mak_mutex_pkg.sv
// mak_mutex_pkg: shared types and widths for the hardware mutex controller.
//   mutex_op_e     - request opcode (LOCK/TRYLOCK/UNLOCK/CANCEL)
//   mutex_status_e - response code returned to the requesting task
//   mutex_state_e  - controller FSM state
package mak_mutex_pkg;

    localparam int TASK_ID_W  = 3;
    localparam int MUTEX_ID_W = 4;
    localparam int PRIO_W     = 4;

    typedef enum logic [1:0] {
        OP_LOCK    = 2'd0,
        OP_TRYLOCK = 2'd1,
        OP_UNLOCK  = 2'd2,
        OP_CANCEL  = 2'd3
    } mutex_op_e;

    typedef enum logic [2:0] {
        ST_OK                  = 3'd0,
        ST_QUEUED              = 3'd1,
        ST_BUSY                = 3'd2,
        ST_ERR_NOT_OWNER       = 3'd3,
        ST_ERR_RECURSIVE       = 3'd4,
        ST_ERR_NOT_WAITING     = 3'd5,
        ST_ERR_ALREADY_WAITING = 3'd6
    } mutex_status_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXEC    = 2'd1,
        S_HANDOFF = 2'd2
    } mutex_state_e;

endpackage

// File: rtl/mutex_waiter_select.sv
// mutex_waiter_select: combinational pick of the highest-priority waiter.
//   i_waiters - waiter bitmap of one mutex (bit per task)
//   i_prio    - base priority per task, higher value wins
//   o_winner  - selected task ID (lowest ID on equal priority)
//   o_valid   - at least one waiter present
module mutex_waiter_select
    import mak_mutex_pkg::*;
#(
    parameter int TASK_COUNT = 8
) (
    input  logic [TASK_COUNT-1:0]             i_waiters,
    input  logic [TASK_COUNT-1:0][PRIO_W-1:0] i_prio,
    output logic [TASK_ID_W-1:0]              o_winner,
    output logic                              o_valid
);

    logic [PRIO_W-1:0] w_best;

    // Ascending scan with a strict '>' keeps the lowest ID on ties.
    always_comb begin
        o_winner = '0;
        o_valid  = 1'b0;
        w_best   = '0;
        for (int t = 0; t < TASK_COUNT; t++) begin
            if (i_waiters[t] && (!o_valid || (i_prio[t] > w_best))) begin
                o_valid  = 1'b1;
                w_best   = i_prio[t];
                o_winner = TASK_ID_W'(t);
            end
        end
    end

endmodule

// File: rtl/hw_mutex_ctrl.sv
// hw_mutex_ctrl: serialises lock/trylock/unlock/cancel requests and keeps
// per-mutex lock flag, owner and waiter bitmap. An unlock with waiters hands
// ownership straight to the best waiter so the mutex never reads free.
//   i_clk/i_rst                 - clock, synchronous active-high reset
//   i_req_*/o_req_ready         - request channel (accepted only in IDLE)
//   i_task_priority             - per-task base priority
//   o_rsp_*                     - one-cycle response pulse
//   o_grant_*                   - one-cycle handoff pulse
//   o_mutex_locked/_owner, o_task_waiting_for_mutex - live status
module hw_mutex_ctrl
    import mak_mutex_pkg::*;
#(
    parameter int TASK_COUNT  = 8,
    parameter int MUTEX_COUNT = 16
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_req_valid,
    output logic                                  o_req_ready,
    input  logic [1:0]                            i_req_op,
    input  logic [TASK_ID_W-1:0]                  i_req_task,
    input  logic [MUTEX_ID_W-1:0]                 i_req_mutex,
    input  logic [TASK_COUNT-1:0][PRIO_W-1:0]     i_task_priority,
    output logic                                  o_rsp_valid,
    output logic [2:0]                            o_rsp_status,
    output logic [TASK_ID_W-1:0]                  o_rsp_task,
    output logic                                  o_grant_valid,
    output logic [TASK_ID_W-1:0]                  o_grant_task,
    output logic [MUTEX_ID_W-1:0]                 o_grant_mutex,
    output logic [MUTEX_COUNT-1:0]                o_mutex_locked,
    output logic [MUTEX_COUNT-1:0][TASK_ID_W-1:0] o_mutex_owner,
    output logic [MUTEX_COUNT-1:0][TASK_COUNT-1:0] o_task_waiting_for_mutex
);

    mutex_state_e                          r_state, w_next;
    mutex_op_e                             r_op;
    logic [TASK_ID_W-1:0]                  r_task;
    logic [MUTEX_ID_W-1:0]                 r_mutex;
    logic [MUTEX_COUNT-1:0]                r_locked;
    logic [MUTEX_COUNT-1:0][TASK_ID_W-1:0] r_owner;
    logic [MUTEX_COUNT-1:0][TASK_COUNT-1:0] r_wait;
    logic                                  r_rsp_valid;
    mutex_status_e                         r_rsp_status;
    logic [TASK_ID_W-1:0]                  r_rsp_task;
    logic                                  r_grant_valid;
    logic [TASK_ID_W-1:0]                  r_grant_task;
    logic [MUTEX_ID_W-1:0]                 r_grant_mutex;

    logic                                  w_cur_locked, w_is_owner, w_task_waiting;
    logic                                  w_my_wait, w_has_waiters;
    logic                                  w_set_lock, w_set_wait, w_clr_wait, w_release, w_go_handoff;
    mutex_status_e                         w_status;
    logic [TASK_ID_W-1:0]                  w_sel_task;
    logic                                  w_sel_valid;

    mutex_waiter_select #(.TASK_COUNT(TASK_COUNT)) u_sel (
        .i_waiters (r_wait[r_mutex]),
        .i_prio    (i_task_priority),
        .o_winner  (w_sel_task),
        .o_valid   (w_sel_valid)
    );

    assign w_cur_locked  = r_locked[r_mutex];
    assign w_is_owner    = w_cur_locked && (r_owner[r_mutex] == r_task);
    assign w_my_wait     = r_wait[r_mutex][r_task];
    assign w_has_waiters = |r_wait[r_mutex];

    always_comb begin
        w_task_waiting = 1'b0;
        for (int m = 0; m < MUTEX_COUNT; m++)
            w_task_waiting = w_task_waiting | r_wait[m][r_task];
    end

    // Decode of the latched request against current state (used in EXEC).
    // A task that is already blocked on some mutex cannot issue a new lock,
    // so that check comes before the free/held evaluation.
    always_comb begin
        w_status     = ST_OK;
        w_set_lock   = 1'b0;
        w_set_wait   = 1'b0;
        w_clr_wait   = 1'b0;
        w_release    = 1'b0;
        w_go_handoff = 1'b0;
        case (r_op)
            OP_LOCK, OP_TRYLOCK: begin
                if (w_task_waiting)          w_status = ST_ERR_ALREADY_WAITING;
                else if (!w_cur_locked)      w_set_lock = 1'b1;
                else if (w_is_owner)         w_status = ST_ERR_RECURSIVE;
                else if (r_op == OP_LOCK) begin
                    w_status   = ST_QUEUED;
                    w_set_wait = 1'b1;
                end else                     w_status = ST_BUSY;
            end
            OP_UNLOCK: begin
                if (!w_is_owner)             w_status = ST_ERR_NOT_OWNER;
                else if (w_has_waiters)      w_go_handoff = 1'b1;
                else                         w_release = 1'b1;
            end
            default: begin
                if (w_my_wait)               w_clr_wait = 1'b1;
                else                         w_status = ST_ERR_NOT_WAITING;
            end
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_req_valid) w_next = S_EXEC;
            S_EXEC:    w_next = w_go_handoff ? S_HANDOFF : S_IDLE;
            S_HANDOFF: w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op          <= OP_LOCK;
            r_task        <= '0;
            r_mutex       <= '0;
            r_locked      <= '0;
            r_owner       <= '0;
            r_wait        <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_status  <= ST_OK;
            r_rsp_task    <= '0;
            r_grant_valid <= 1'b0;
            r_grant_task  <= '0;
            r_grant_mutex <= '0;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_grant_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (i_req_valid) begin
                    r_op    <= mutex_op_e'(i_req_op);
                    r_task  <= i_req_task;
                    r_mutex <= i_req_mutex;
                end
                S_EXEC: begin
                    r_rsp_valid  <= 1'b1;
                    r_rsp_status <= w_status;
                    r_rsp_task   <= r_task;
                    if (w_set_lock) begin
                        r_locked[r_mutex] <= 1'b1;
                        r_owner[r_mutex]  <= r_task;
                    end
                    if (w_set_wait) r_wait[r_mutex][r_task] <= 1'b1;
                    if (w_clr_wait) r_wait[r_mutex][r_task] <= 1'b0;
                    // Owner field is left stale on a plain release.
                    if (w_release)  r_locked[r_mutex] <= 1'b0;
                end
                S_HANDOFF: if (w_sel_valid) begin
                    r_owner[r_mutex]            <= w_sel_task;
                    r_wait[r_mutex][w_sel_task] <= 1'b0;
                    r_grant_valid               <= 1'b1;
                    r_grant_task                <= w_sel_task;
                    r_grant_mutex               <= r_mutex;
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready              = (r_state == S_IDLE);
    assign o_rsp_valid              = r_rsp_valid;
    assign o_rsp_status             = r_rsp_status;
    assign o_rsp_task               = r_rsp_task;
    assign o_grant_valid            = r_grant_valid;
    assign o_grant_task             = r_grant_task;
    assign o_grant_mutex            = r_grant_mutex;
    assign o_mutex_locked           = r_locked;
    assign o_mutex_owner            = r_owner;
    assign o_task_waiting_for_mutex = r_wait;

endmodule
